// File: rtl/fifo_lookahead_upsizer_if.sv
// Lookahead read ports around the upsizer: narrow side (empty_i/rd_i/dout_i) and wide side (empty/rd/dout).
// Defining FIFO_UPSIZER_FLUSH_EN adds flush and dout_beats.
interface fifo_lookahead_upsizer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
);
  // Lookahead handshake on both sides: data is valid whenever empty is low,
  // and a pop (rd) consumes that data at the same clock edge; rd while empty is ignored.
  logic                        empty_i;
  logic                        rd_i;
  logic [DATA_WIDTH-1:0]       dout_i;
  logic                        empty;
  logic                        rd;
  logic [DATA_WIDTH*RATIO-1:0] dout;
`ifdef FIFO_UPSIZER_FLUSH_EN
  logic                        flush;
  logic [$clog2(RATIO+1)-1:0]  dout_beats;

  modport slave  (input  empty_i, dout_i, rd, flush, output rd_i, empty, dout, dout_beats);
  modport master (output empty_i, dout_i, rd, flush, input  rd_i, empty, dout, dout_beats);
`else
  modport slave  (input  empty_i, dout_i, rd, output rd_i, empty, dout);
  modport master (output empty_i, dout_i, rd, input  rd_i, empty, dout);
`endif
endinterface

// File: rtl/fifo_lookahead_upsizer.sv
// Packs RATIO narrow lookahead-FIFO beats into one wide word exposed on a lookahead read port.
// Optional partial-word flush is enabled by defining FIFO_UPSIZER_FLUSH_EN.
module fifo_lookahead_upsizer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int REVERSED   = 0
) (
  input logic                     clk,
  input logic                     rst,
  fifo_lookahead_upsizer_if.slave bus
);
  localparam int WW = DATA_WIDTH * RATIO;
  localparam int CW = $clog2(RATIO);
  localparam int BW = $clog2(RATIO + 1);

  logic [WW-1:0] asm_q, asm_d;
  logic [WW-1:0] dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [WW-1:0] merged, word;
  logic [BW-1:0] fill;
  logic          out_free, last, pop, load;
`ifdef FIFO_UPSIZER_FLUSH_EN
  logic [BW-1:0] beats_q, beats_d;
  logic          flush_hit;
`endif

  function automatic int slot(input int k);
    return (REVERSED != 0) ? (RATIO - 1 - k) : k;
  endfunction

  always_comb begin
    out_free = !valid_q || bus.rd;
    last     = (cnt_q == CW'(RATIO - 1));
    pop      = rst && !bus.empty_i && (!last || out_free);
    fill     = BW'(cnt_q) + BW'(pop);
    merged   = asm_q;
    if (pop) merged[slot(int'(cnt_q))*DATA_WIDTH +: DATA_WIDTH] = bus.dout_i;
    // Only beats of the current word are exposed; stale slices read as zero.
    word = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(fill))
        word[slot(k)*DATA_WIDTH +: DATA_WIDTH] = merged[slot(k)*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef FIFO_UPSIZER_FLUSH_EN
    flush_hit = bus.flush && out_free && (fill != '0);
    load      = (pop && last) || flush_hit;
`else
    load      = pop && last;
`endif
  end

  always_comb begin
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dout_d  = dout_q;
`ifdef FIFO_UPSIZER_FLUSH_EN
    beats_d = beats_q;
`endif
    if (pop) begin
      asm_d = merged;
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
    if (valid_q && bus.rd) valid_d = 1'b0;
    // A load in the same cycle as a pop of the held word replaces it with no bubble.
    if (load) begin
      dout_d  = word;
      valid_d = 1'b1;
      cnt_d   = '0;
`ifdef FIFO_UPSIZER_FLUSH_EN
      beats_d = fill;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      asm_q   <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
`ifdef FIFO_UPSIZER_FLUSH_EN
      beats_q <= '0;
`endif
    end else begin
      asm_q   <= asm_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
`ifdef FIFO_UPSIZER_FLUSH_EN
      beats_q <= beats_d;
`endif
    end
  end

  assign bus.rd_i  = pop;
  assign bus.empty = !valid_q;
  assign bus.dout  = dout_q;
`ifdef FIFO_UPSIZER_FLUSH_EN
  assign bus.dout_beats = beats_q;
`endif
endmodule

// File: tb/tb_fifo_lookahead_upsizer.sv
// Bench for fifo_lookahead_upsizer: normal and REVERSED instances fed identical stimulus,
// directed cases plus randomized streams scored against words built from the source beats.
module tb_fifo_lookahead_upsizer;
  localparam int W  = 8;
  localparam int R  = 4;
  localparam int WW = W * R;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_lookahead_upsizer_if #(.DATA_WIDTH(W), .RATIO(R)) if_n ();
  fifo_lookahead_upsizer_if #(.DATA_WIDTH(W), .RATIO(R)) if_r ();

  assign if_r.empty_i = if_n.empty_i;
  assign if_r.dout_i  = if_n.dout_i;
  assign if_r.rd      = if_n.rd;
`ifdef FIFO_UPSIZER_FLUSH_EN
  assign if_r.flush   = if_n.flush;
`endif

  fifo_lookahead_upsizer #(.DATA_WIDTH(W), .RATIO(R), .REVERSED(0)) dut_n (.clk(clk), .rst(rst), .bus(if_n));
  fifo_lookahead_upsizer #(.DATA_WIDTH(W), .RATIO(R), .REVERSED(1)) dut_r (.clk(clk), .rst(rst), .bus(if_r));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    if_n.empty_i = 1'b1;
    if_n.rd      = 1'b0;
`ifdef FIFO_UPSIZER_FLUSH_EN
    if_n.flush   = 1'b0;
`endif
    rst = 1'b0;
    nxt();
    nxt();
    rst = 1'b1;
  endtask

  // Source FIFO model and expected-word scoreboard
  logic [W-1:0]  src_q[$];
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] exp_r_q[$];
  bit src_en    = 0;
  bit sb_en     = 0;
  bit cont_mode = 0;
  int cyc       = 0;
  int last_out  = 0;
  int words_out = 0;

  always @(posedge clk) begin
    if (src_en) begin
      #1;
      if_n.empty_i = (src_q.size() == 0) || (!cont_mode && $urandom_range(0, 3) == 0);
      if_n.dout_i  = (src_q.size() != 0) ? src_q[0] : '0;
      if_n.rd      = cont_mode ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (sb_en) begin
      chk("rd_i_while_empty_i", WW'(if_n.rd_i & if_n.empty_i), '0);
      if (cont_mode && !if_n.empty_i) chk("rd_i_no_drop", WW'(if_n.rd_i), WW'(1));
      if (if_n.rd_i && !if_n.empty_i && src_q.size() > 0) void'(src_q.pop_front());
      if (if_n.rd && !if_n.empty) begin
        chk("word_available", WW'(exp_q.size() > 0), WW'(1));
        if (exp_q.size() > 0) chk("stream_word", if_n.dout, exp_q.pop_front());
        if (cont_mode && words_out > 0) chk("word_spacing", WW'(cyc - last_out), WW'(R));
        last_out = cyc;
        words_out++;
      end
      if (if_r.rd && !if_r.empty) begin
        chk("word_available_rev", WW'(exp_r_q.size() > 0), WW'(1));
        if (exp_r_q.size() > 0) chk("stream_word_rev", if_r.dout, exp_r_q.pop_front());
      end
    end
  end

  task automatic run_stream(input int nbeats, input bit cont);
    logic [W-1:0]  grp[R];
    logic [WW-1:0] wn, wr;
    do_reset();
    src_q.delete();
    exp_q.delete();
    exp_r_q.delete();
    for (int b = 0; b < nbeats; b++) begin
      grp[b % R] = W'($urandom_range(0, 255));
      src_q.push_back(grp[b % R]);
      if (b % R == R - 1) begin
        wn = '0;
        wr = '0;
        for (int k = 0; k < R; k++) begin
          wn[k*W +: W]       = grp[k];
          wr[(R-1-k)*W +: W] = grp[k];
        end
        exp_q.push_back(wn);
        exp_r_q.push_back(wr);
      end
    end
    cont_mode = cont;
    words_out = 0;
    sb_en     = 1;
    src_en    = 1;
    for (int i = 0; i < 2000 && words_out < nbeats / R; i++) @(posedge clk);
    src_en = 0;
    sb_en  = 0;
    chk("stream_words_done", WW'(words_out), WW'(nbeats / R));
    chk("stream_src_drained", WW'(src_q.size()), '0);
    #2;
    if_n.empty_i = 1'b1;
    if_n.rd      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset holds everything idle even with data offered and rd asserted
    rst          = 1'b0;
    if_n.empty_i = 1'b0;
    if_n.dout_i  = 8'h5A;
    if_n.rd      = 1'b1;
`ifdef FIFO_UPSIZER_FLUSH_EN
    if_n.flush   = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      smp();
      chk("rst_rd_i", WW'(if_n.rd_i), '0);
      chk("rst_empty", WW'(if_n.empty), WW'(1));
      chk("rst_dout", if_n.dout, '0);
      chk("rst_dout_rev", if_r.dout, '0);
    end

    // Single word, both slice orders
    do_reset();
    if_n.rd = 1'b1;
    for (int i = 0; i < R; i++) begin
      if_n.empty_i = 1'b0;
      if_n.dout_i  = W'(i + 1);
      smp();
      chk("t2_rd_i", WW'(if_n.rd_i), WW'(1));
      chk("t2_empty_before", WW'(if_n.empty), WW'(1));
      nxt();
    end
    if_n.empty_i = 1'b1;
    smp();
    chk("t2_empty", WW'(if_n.empty), '0);
    chk("t2_dout", if_n.dout, 32'h04030201);
    chk("t3_dout_rev", if_r.dout, 32'h01020304);
`ifdef FIFO_UPSIZER_FLUSH_EN
    chk("t2_beats_full", WW'(if_n.dout_beats), WW'(R));
`endif
    nxt();
    if_n.rd = 1'b0;
    smp();
    chk("t2_empty_after", WW'(if_n.empty), WW'(1));
    chk("t2_dout_hold", if_n.dout, 32'h04030201);

    // Backpressure: stall on the last beat of the second word until rd
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if_n.empty_i = 1'b0;
      if_n.dout_i  = W'(8'h11 + i);
      smp();
      chk("t4_rd_i", WW'(if_n.rd_i), WW'(1));
      nxt();
    end
    if_n.dout_i = 8'h18;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("t4_stall_rd_i", WW'(if_n.rd_i), '0);
      chk("t4_held_empty", WW'(if_n.empty), '0);
      chk("t4_held_dout", if_n.dout, 32'h14131211);
      nxt();
    end
    if_n.rd = 1'b1;
    smp();
    chk("t4_release_rd_i", WW'(if_n.rd_i), WW'(1));
    nxt();
    if_n.rd      = 1'b0;
    if_n.empty_i = 1'b1;
    smp();
    chk("t4_second_empty", WW'(if_n.empty), '0);
    chk("t4_second_dout", if_n.dout, 32'h18171615);
    chk("t4_second_dout_rev", if_r.dout, 32'h15161718);
    if_n.rd = 1'b1;
    nxt();
    if_n.rd = 1'b0;
    smp();
    chk("t4_drained", WW'(if_n.empty), WW'(1));

`ifdef FIFO_UPSIZER_FLUSH_EN
    // Partial-word flush, then a flush with nothing assembled
    do_reset();
    if_n.empty_i = 1'b0;
    if_n.dout_i  = 8'hAA;
    nxt();
    if_n.dout_i  = 8'hBB;
    nxt();
    if_n.empty_i = 1'b1;
    if_n.flush   = 1'b1;
    nxt();
    if_n.flush   = 1'b0;
    smp();
    chk("t6_flush_empty", WW'(if_n.empty), '0);
    chk("t6_flush_dout", if_n.dout, 32'h0000BBAA);
    chk("t6_flush_dout_rev", if_r.dout, 32'hAABB0000);
    chk("t6_flush_beats", WW'(if_n.dout_beats), WW'(2));
    if_n.rd = 1'b1;
    nxt();
    if_n.rd    = 1'b0;
    if_n.flush = 1'b1;
    nxt();
    if_n.flush = 1'b0;
    smp();
    chk("t6_flush_idle", WW'(if_n.empty), WW'(1));
`endif

    // Continuous rd with no gaps, then random gaps and random rd
    run_stream(16, 1'b1);
    run_stream(40, 1'b0);
    run_stream(64, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
